ldm_wb_sequencer: RTL and testbench

Multi-cycle load-multiple writeback sequencer for the ARM pipeline. It drives the write port of the register file (WB_EN / WB_Dest / WB_Res) for LDM-style instructions. Given a register list and a base address, it issues one memory read per listed register, writes each returned word to its register in ascending register order, and optionally writes back the updated base. It replaces the single-result writeback path while busy, and holds the pipeline frozen via `busy`.

---
 rtl/ldm_wb_sequencer_if.sv | 38 +++
 rtl/ldm_wb_sequencer.sv | 150 +++++++++++++++
 tb/tb_ldm_wb_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ldm_wb_sequencer_if.sv
// Bus bundle for the load-multiple writeback sequencer: launch inputs, memory read port,
// register-file write port and status. The sequencer takes the master view.
interface ldm_wb_sequencer_if;
  logic        start;
  logic [14:0] reg_list;
  logic [31:0] base_addr;
  logic        up;
  logic        wback;
  logic [3:0]  base_reg;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        WB_EN;
  logic [3:0]  WB_Dest;
  logic [31:0] WB_Res;

  logic        busy;
  logic        done;

  modport master (
    input  start, reg_list, base_addr, up, wback, base_reg,
    input  mem_ack, mem_rdata,
    output mem_req, mem_addr,
    output WB_EN, WB_Dest, WB_Res,
    output busy, done
  );

  modport slave (
    output start, reg_list, base_addr, up, wback, base_reg,
    output mem_ack, mem_rdata,
    input  mem_req, mem_addr,
    input  WB_EN, WB_Dest, WB_Res,
    input  busy, done
  );
endinterface

// File: rtl/ldm_wb_sequencer.sv
// LDM writeback sequencer: one memory read per listed register, ascending register order,
// followed by an optional base-register writeback. Outputs decode only from registered state.
module ldm_wb_sequencer (
  input  logic              clk,
  input  logic              rst,
  ldm_wb_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WRITE,
    BASEWB,
    DONE
  } state_e;

  state_e      state_q,    state_d;
  logic [14:0] list_q,     list_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] data_q,     data_d;
  logic [31:0] wb_val_q,   wb_val_d;
  logic [3:0]  base_reg_q, base_reg_d;
  logic        do_bwb_q,   do_bwb_d;

  logic [4:0]  start_cnt;
  logic [31:0] start_span;
  logic [15:0] start_list_ext;
  logic        start_base_in_list;
  logic [14:0] list_remaining;
  logic [3:0]  cur_dest;

  function automatic logic [4:0] popcount15(input logic [14:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 15; i++) begin
      cnt = cnt + {4'b0000, v[i]};
    end
    return cnt;
  endfunction

  // Scanning downward lets the lowest set bit be the last (winning) assignment.
  function automatic logic [3:0] lowest_bit(input logic [14:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 14; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    start_cnt          = popcount15(bus.reg_list);
    start_span         = {25'd0, start_cnt, 2'b00};
    start_list_ext     = {1'b0, bus.reg_list};
    start_base_in_list = start_list_ext[bus.base_reg];
    list_remaining     = list_q & (list_q - 15'd1);
    cur_dest           = lowest_bit(list_q);
  end

  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wb_val_d   = wb_val_q;
    base_reg_d = base_reg_q;
    do_bwb_d   = do_bwb_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          list_d     = bus.reg_list;
          base_reg_d = bus.base_reg;
          // A base register that is also loaded keeps the loaded value.
          do_bwb_d   = bus.wback && (bus.base_reg != 4'hF) && !start_base_in_list;
          wb_val_d   = bus.up ? (bus.base_addr + start_span) : (bus.base_addr - start_span);
          addr_d     = bus.up ? bus.base_addr : (bus.base_addr - start_span);
          state_d    = (start_cnt == 5'd0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          data_d  = bus.mem_rdata;
          state_d = WRITE;
        end
      end
      WRITE: begin
        list_d = list_remaining;
        addr_d = addr_q + 32'd4;
        if (list_remaining != 15'd0) begin
          state_d = REQ;
        end else if (do_bwb_q) begin
          state_d = BASEWB;
        end else begin
          state_d = DONE;
        end
      end
      BASEWB: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      list_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wb_val_q   <= '0;
      base_reg_q <= '0;
      do_bwb_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      list_q     <= list_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wb_val_q   <= wb_val_d;
      base_reg_q <= base_reg_d;
      do_bwb_q   <= do_bwb_d;
    end
  end

  // Outputs are zero outside the states that own them, so idle buses read as quiet.
  always_comb begin
    bus.mem_req  = (state_q == REQ);
    bus.mem_addr = (state_q == REQ) ? addr_q : 32'd0;
    bus.WB_EN    = (state_q == WRITE) || (state_q == BASEWB);
    bus.WB_Dest  = 4'd0;
    bus.WB_Res   = 32'd0;
    if (state_q == WRITE) begin
      bus.WB_Dest = cur_dest;
      bus.WB_Res  = data_q;
    end else if (state_q == BASEWB) begin
      bus.WB_Dest = base_reg_q;
      bus.WB_Res  = wb_val_q;
    end
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
  end

endmodule

// File: tb/tb_ldm_wb_sequencer.sv
// Bench for ldm_wb_sequencer: each transaction is turned into a per-cycle expected schedule
// from the timing rules, and a negedge process compares every output against it.
module tb_ldm_wb_sequencer;

  localparam int MAXC = 128;

  logic clk;
  logic rst;

  ldm_wb_sequencer_if bus ();

  ldm_wb_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        expReq   [MAXC];
  logic [31:0] expAddr  [MAXC];
  logic        expWb    [MAXC];
  logic [3:0]  expDest  [MAXC];
  logic [31:0] expRes   [MAXC];
  logic        expDone  [MAXC];
  logic        ackDrv   [MAXC];
  logic [31:0] rdataDrv [MAXC];
  logic [31:0] dataPlan [15];
  int  t0 = 0;
  int  doneCycle = 0;
  bit  schedValid = 1'b0;
  int  wbPulses = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Compare process: full output vector every cycle against the active schedule.
  always @(negedge clk) begin
    int c;
    if (schedValid && !rst) begin
      c = cyc - t0;
      if (c >= 0 && c <= doneCycle) begin
        checkOutput("busy", {31'd0, bus.busy}, {31'd0, (c >= 1)});
        checkOutput("mem_req", {31'd0, bus.mem_req}, {31'd0, expReq[c]});
        if (expReq[c]) checkOutput("mem_addr", bus.mem_addr, expAddr[c]);
        checkOutput("WB_EN", {31'd0, bus.WB_EN}, {31'd0, expWb[c]});
        if (expWb[c]) begin
          checkOutput("WB_Dest", {28'd0, bus.WB_Dest}, {28'd0, expDest[c]});
          checkOutput("WB_Res", bus.WB_Res, expRes[c]);
        end
        checkOutput("done", {31'd0, bus.done}, {31'd0, expDone[c]});
      end else if (c > doneCycle) begin
        checkOutput("idle busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("idle mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("idle WB_EN", {31'd0, bus.WB_EN}, 32'd0);
        checkOutput("idle done", {31'd0, bus.done}, 32'd0);
      end
    end
    if (bus.WB_EN) wbPulses++;
  end

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " mem_req"}, {31'd0, bus.mem_req}, 32'd0);
    checkOutput({tag, " mem_addr"}, bus.mem_addr, 32'd0);
    checkOutput({tag, " WB_EN"}, {31'd0, bus.WB_EN}, 32'd0);
    checkOutput({tag, " WB_Dest"}, {28'd0, bus.WB_Dest}, 32'd0);
    checkOutput({tag, " WB_Res"}, bus.WB_Res, 32'd0);
    checkOutput({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
    checkOutput({tag, " done"}, {31'd0, bus.done}, 32'd0);
  endtask

  // One transaction starting in the next cycle (cycle 0). Waits per read are drawn from
  // [waitMin, waitMax]; read data comes from dataPlan. resetAt >= 0 aborts with rst in that cycle.
  task automatic applyStimulus(input logic [14:0] list, input logic [31:0] base, input logic up,
                               input logic wb, input logic [3:0] breg, input int waitMin,
                               input int waitMax, input bit overlap, input int resetAt);
    int regs[$];
    int n;
    int c;
    logic [31:0] addr0;
    logic [31:0] span;
    @(posedge clk);
    #1;
    for (int i = 0; i < MAXC; i++) begin
      expReq[i] = 1'b0; expAddr[i] = '0; expWb[i] = 1'b0; expDest[i] = '0;
      expRes[i] = '0; expDone[i] = 1'b0; ackDrv[i] = 1'b0; rdataDrv[i] = '0;
    end
    regs.delete();
    for (int i = 0; i < 15; i++) if (list[i]) regs.push_back(i);
    n = regs.size();
    span = 32'(n) * 32'd4;
    addr0 = up ? base : base - span;
    c = 1;
    for (int k = 0; k < n; k++) begin
      int w;
      w = $urandom_range(waitMax, waitMin);
      for (int j = 0; j <= w; j++) begin
        expReq[c] = 1'b1;
        expAddr[c] = addr0 + 32'(k) * 32'd4;
        if (j == w) begin
          ackDrv[c] = 1'b1;
          rdataDrv[c] = dataPlan[k];
        end
        c++;
      end
      expWb[c] = 1'b1; expDest[c] = 4'(regs[k]); expRes[c] = dataPlan[k];
      c++;
    end
    if (n > 0 && wb && !list[breg]) begin
      expWb[c] = 1'b1; expDest[c] = breg; expRes[c] = up ? base + span : base - span;
      c++;
    end
    expDone[c] = 1'b1;
    doneCycle = c;
    t0 = cyc;
    wbPulses = 0;
    schedValid = 1'b1;
    bus.start = 1'b1; bus.reg_list = list; bus.base_addr = base;
    bus.up = up; bus.wback = wb; bus.base_reg = breg;
    bus.mem_ack = 1'($urandom_range(1, 0)); bus.mem_rdata = $urandom;
    for (int cc = 1; cc <= doneCycle; cc++) begin
      @(posedge clk);
      #1;
      if (cc == resetAt) begin
        checkOutput("pre-reset mem_req", {31'd0, bus.mem_req}, {31'd0, expReq[cc]});
        schedValid = 1'b0;
        bus.mem_ack = 1'b0;
        rst = 1'b1;
        #1;
        checkQuiet("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      bus.start = overlap ? 1'($urandom_range(1, 0)) : 1'b0;
      if (overlap) begin
        bus.reg_list = 15'($urandom); bus.base_addr = $urandom;
        bus.up = 1'($urandom); bus.wback = 1'($urandom); bus.base_reg = 4'($urandom_range(14, 0));
      end
      if (ackDrv[cc]) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = rdataDrv[cc];
      end else begin
        bus.mem_ack = expReq[cc] ? 1'b0 : 1'($urandom_range(1, 0));
        bus.mem_rdata = $urandom;
      end
    end
    bus.start = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.reg_list = '0; bus.base_addr = '0; bus.up = 1'b0;
    bus.wback = 1'b0; bus.base_reg = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 15; i++) dataPlan[i] = $urandom;
    #2;
    checkQuiet("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Ascending, no writeback, zero wait.
    dataPlan[0] = 32'hA; dataPlan[1] = 32'hB;
    applyStimulus(15'h0005, 32'h100, 1'b1, 1'b0, 4'd0, 0, 0, 1'b0, -1);
    checkOutput("model t1 addr0", expAddr[1], 32'h100);
    checkOutput("model t1 addr1", expAddr[3], 32'h104);
    checkOutput("model t1 wb R0", {expDest[2], expRes[2][27:0]}, {4'd0, 28'hA});
    checkOutput("model t1 wb R2", {expDest[4], expRes[4][27:0]}, {4'd2, 28'hB});
    checkOutput("model t1 done", 32'(doneCycle), 32'd5);

    // Decrement-before with base writeback.
    dataPlan[0] = $urandom; dataPlan[1] = $urandom;
    applyStimulus(15'h000A, 32'h200, 1'b0, 1'b1, 4'd13, 0, 0, 1'b0, -1);
    checkOutput("model t2 addr0", expAddr[1], 32'h1F8);
    checkOutput("model t2 addr1", expAddr[3], 32'h1FC);
    checkOutput("model t2 basewb", {expDest[5], expRes[5][27:0]}, {4'd13, 28'h1F8});
    checkOutput("model t2 done", 32'(doneCycle), 32'd6);

    // Base register in the list: loaded value wins, exactly two writes.
    dataPlan[0] = $urandom; dataPlan[1] = $urandom;
    applyStimulus(15'h2001, 32'h400, 1'b1, 1'b1, 4'd13, 0, 0, 1'b0, -1);
    checkOutput("base-in-list wb pulses", 32'(wbPulses), 32'd2);

    // Three-cycle wait states with overlapping start pulses.
    applyStimulus(15'h0111, 32'h800, 1'b1, 1'b1, 4'd2, 3, 3, 1'b1, -1);

    // Empty list.
    applyStimulus(15'h0000, 32'h100, 1'b1, 1'b1, 4'd3, 0, 0, 1'b0, -1);
    checkOutput("model empty done", 32'(doneCycle), 32'd1);
    checkOutput("empty wb pulses", 32'(wbPulses), 32'd0);

    // Reset in REQ with two registers remaining, then a clean transfer.
    applyStimulus(15'h0070, 32'h300, 1'b1, 1'b1, 4'd1, 0, 0, 1'b0, 3);
    for (int i = 0; i < 15; i++) dataPlan[i] = $urandom;
    applyStimulus(15'h0070, 32'h300, 1'b1, 1'b1, 4'd1, 0, 0, 1'b0, -1);

    // Address wrap.
    applyStimulus(15'h0007, 32'hFFFF_FFF8, 1'b1, 1'b1, 4'd9, 0, 1, 1'b0, -1);

    // Randomized transfers.
    for (int t = 0; t < 40; t++) begin
      logic [14:0] l;
      logic [31:0] b;
      int mode;
      for (int i = 0; i < 15; i++) dataPlan[i] = $urandom;
      mode = $urandom_range(9, 0);
      l = (mode == 0) ? 15'h0000 : (mode == 1) ? 15'h7FFF : 15'($urandom);
      b = (mode == 2) ? 32'hFFFF_FFF0 : (mode == 3) ? 32'h0000_0008 : ($urandom & 32'hFFFF_FFFC);
      applyStimulus(l, b, 1'($urandom), 1'($urandom), 4'($urandom_range(14, 0)),
                    0, 3, 1'($urandom), -1);
      if ($urandom_range(3, 0) == 0) begin
        repeat ($urandom_range(3, 1)) @(posedge clk);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
